muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Multi-cycle MIPS multiply/divide unit that owns the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from the execute stage.
- Drives the `hi`/`lo` values consumed by the ALU for MFHI/MFLO/MUL.
- Raises `busy` so the pipeline stalls any HI/LO reader or new mul/div request until the result is committed.

Parameters:
- MUL_CYCLES, 2, busy cycles for MULT/MULTU (pipelined signed 33x33 product); legal range 1..4.
- DIV_CYCLES, 33, busy cycles for DIV/DIVU (32 radix-2 iterations + 1 sign-fixup); fixed, not overridable.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- req  input  1  operation request, qualified by !busy.
- op  input  3  md_op_t operation code.
- srca  input  32  rs operand.
- srcb  input  32  rt operand.
- flush  input  1  exception/eret flush; cancels the in-flight operation.
- busy  output  1  operation in progress; HI/LO not yet final.
- done  output  1  one-cycle pulse in the cycle HI/LO first show a new mul/div result.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.

Behaviour:
- One clock; reset is synchronous and active-high. Reset values: hi=0, lo=0, busy=0, done=0, FSM=IDLE.
- FSM states: IDLE, MUL_RUN, DIV_RUN.
- Acceptance: req=1 && !busy && !flush at edge T, with op in {MULT, MULTU, DIV, DIVU}.
  - Operands latch at T; FSM enters MUL_RUN or DIV_RUN.
  - busy=1 for exactly N cycles, N = MUL_CYCLES or DIV_CYCLES.
  - hi/lo are written on the edge ending the Nth cycle. In the following cycle: busy=0, done=1, new hi/lo visible.
- While busy=1, req is ignored; no state change from req. The issuer must hold the instruction.
- MTHI/MTLO: accepted when !busy; write hi (or lo) from srca on the same edge; visible next cycle. busy stays 0 and done stays 0.
- op=MD_NONE with req=1: no effect.
- MULT: {hi,lo} = signed(srca)*signed(srcb). MULTU: unsigned product. Full 64-bit result.
- DIVU: lo = srca/srcb, hi = srca%srcb, unsigned.
- DIV:
  - Divide magnitudes.
  - Quotient negated if sign(srca)^sign(srcb).
  - Remainder takes the sign of srca.
- Division boundary cases:
  - srcb=0, any signedness: lo=32'hFFFF_FFFF, hi=srca, full DIV_CYCLES latency.
  - DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0, no exception.
- flush=1 in any cycle: FSM→IDLE on that edge; in-flight result discarded; hi/lo unchanged; busy=0 and done=0 next cycle.
  - flush with a simultaneous req: flush wins and the request is dropped, including MTHI/MTLO.
  - flush in the final busy cycle: result is discarded.
- reset mid-operation: same as flush, and hi/lo clear to 0.
- No combinational path from req/op/srca/srcb to any output.

Decomposition:
- Shared package `muldiv_pkg`:
  - md_op_t enum, 3 bits: MD_NONE=0, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
  - Localparam DIV_ITER=32.
  - The md_op_t decode from the instruction bus lives in the decoder, not here.
- Sub-module `div_radix2`:
  - Unsigned 32/32 restoring divider.
  - Ports: start, dividend, divisor, kill; outputs quotient, remainder, valid.
  - Runs one iteration per cycle.
  - Sign handling and the zero-divisor override stay in muldiv_unit.
- The multiplier stays inline as a MUL_CYCLES-deep register chain on a `*` product.

Test Plan:
- Reset then MTHI srca=32'h1234_5678, next cycle MTLO srca=32'h9ABC_DEF0 → hi=32'h1234_5678, lo=32'h9ABC_DEF0; busy never asserts.
- MULT srca=32'hFFFF_FFFE (-2), srcb=3 → busy exactly 2 cycles, then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA, done pulses 1 cycle. Same operands with MULTU → hi=2, lo=32'hFFFF_FFFA.
- DIV srca=-7, srcb=2 → busy 33 cycles, then lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1). DIVU 7/2 → lo=3, hi=1.
- Boundaries:
  - DIVU 5/0 → lo=32'hFFFF_FFFF, hi=5.
  - DIV 32'h8000_0000 / 32'hFFFF_FFFF → lo=32'h8000_0000, hi=0.
- DIV issued with prior hi=1, lo=2; flush at busy cycle 10 → busy=0 next cycle, hi=1, lo=2, no done. A req held during busy is not accepted; it is accepted the cycle after busy falls.
- reset asserted at busy cycle 1 of MULT → hi=lo=0, busy=0, done never pulses.

Source files
------------

// File: rtl/muldiv_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types and constants for the MIPS multiply/divide unit.
//   md_op_t     : operation code presented by the execute stage
//   md_state_t  : sequencer state, exported on the debug port of muldiv_unit
//   DIV_ITER    : radix-2 iterations of the divider (one quotient bit each)
//   DIV_CYCLES  : busy cycles of a divide (iterations + one sign-fixup cycle)
//   abs32       : two's-complement magnitude helper for signed divide
// -----------------------------------------------------------------------------
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2
  } md_state_t;

  localparam int DIV_ITER   = 32;
  localparam int DIV_CYCLES = DIV_ITER + 1;

  // Magnitude of a two's-complement value. 32'h8000_0000 maps to itself,
  // which read as unsigned is exactly 2^31, the correct magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// muldiv_if
// Request/result bundle between the execute stage (master) and the
// multiply/divide unit (slave).
//   req, op, srca, srcb : operation request and operands (master -> slave)
//   flush               : cancels any in-flight operation (master -> slave)
//   busy, done, hi, lo  : status and architectural HI/LO (slave -> master)
//
// Handshake: a request is taken on a rising edge where req=1, busy=0 and
// flush=0. While busy=1 the slave ignores req and the master must hold the
// instruction; it is taken on the first edge after busy falls. done is a
// single-cycle pulse in the first cycle hi/lo show a new mul/div result.
// MTHI/MTLO complete on their accepting edge and never raise busy or done.
// -----------------------------------------------------------------------------
interface muldiv_if;
  import muldiv_pkg::*;

  logic        req;
  md_op_t      op;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output req, op, srca, srcb, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  req, op, srca, srcb, flush,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_unit_div_radix2.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// div_radix2
// Unsigned 32/32 restoring divider, one quotient bit per clock.
//   clk, rst            : clock, synchronous active-high reset
//   start               : load dividend/divisor and begin DIV_ITER iterations
//   dividend, divisor   : unsigned operands, sampled when start=1
//   kill                : abandon the current division (wins over start)
//   quotient, remainder : result, valid in the cycle valid=1
//   valid               : one-cycle pulse after the last iteration
// A zero divisor is not special-cased here; the caller overrides the result.
// -----------------------------------------------------------------------------
module div_radix2
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        kill,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        valid
);

  logic [31:0] quo_q;   // shifts dividend out, quotient bits in
  logic [31:0] rem_q;   // partial remainder
  logic [31:0] dvs_q;   // latched divisor
  logic [5:0]  cnt_q;   // iterations still to run
  logic        valid_q;

  logic [32:0] shifted;
  logic [31:0] diff;
  logic        take;

  // One restoring step: bring down the next dividend bit and subtract the
  // divisor if it fits. When it fits the difference is below the divisor,
  // so 32 bits hold it even though the shifted value needs 33.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    take    = (shifted >= {1'b0, dvs_q});
    diff    = shifted[31:0] - dvs_q;
  end

  always_ff @(posedge clk) begin
    if (rst || kill) begin
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (start) begin
      quo_q   <= dividend;
      rem_q   <= '0;
      dvs_q   <= divisor;
      cnt_q   <= 6'(DIV_ITER);
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (cnt_q != 6'd0) begin
        quo_q <= {quo_q[30:0], take};
        rem_q <= take ? diff : shifted[31:0];
        cnt_q <= cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign valid     = valid_q;

endmodule

// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// muldiv_unit
// Multi-cycle MIPS multiply/divide unit owning the architectural HI/LO pair.
// Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO and stalls the pipeline via busy
// until a mul/div result is committed.
//   clk         : core clock
//   reset       : synchronous active-high reset (clears HI/LO, cancels work)
//   md          : muldiv_if slave (req/op/srca/srcb/flush in, busy/done/hi/lo out)
//   dbg_state_o : current sequencer state
// Parameter MUL_CYCLES (1..4) sets the multiply latency; divides always take
// DIV_CYCLES. All outputs come straight from registers.
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic      clk,
  input  logic      reset,
  muldiv_if.slave   md,
  output md_state_t dbg_state_o
);

  // Multiply pipeline depth after the combinational product stage.
  localparam int MUL_DEPTH = (MUL_CYCLES > 1) ? MUL_CYCLES - 1 : 1;
  localparam int MUL_TAP   = (MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0;

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  md_state_t   state_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [2:0]  cnt_q;         // current multiply busy cycle, 1-based
  logic [31:0] a_q;           // latched srca (multiplicand / raw dividend)
  logic [31:0] b_q;           // latched srcb (multiplier)
  logic        mul_signed_q;
  logic        q_neg_q;       // signed divide: negate quotient
  logic        r_neg_q;       // signed divide: negate remainder
  logic        dz_q;          // divide by zero

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic        take_req;
  logic        op_is_mul;
  logic        op_is_div;
  logic        op_signed_div;
  logic        div_start;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;

  always_comb begin
    take_req      = md.req && (state_q == IDLE) && !md.flush;
    op_is_mul     = (md.op == MD_MULT) || (md.op == MD_MULTU);
    op_is_div     = (md.op == MD_DIV)  || (md.op == MD_DIVU);
    op_signed_div = (md.op == MD_DIV);
    div_start     = take_req && op_is_div;
    div_dividend  = op_signed_div ? abs32(md.srca) : md.srca;
    div_divisor   = op_signed_div ? abs32(md.srcb) : md.srcb;
  end

  // ---------------------------------------------------------------------------
  // Multiplier: product of the latched operands, then a register chain.
  // Extending to 64 bits with the sign (or zero) bit and keeping the low 64
  // bits of the product is exactly the signed 33x33 product's low half.
  // ---------------------------------------------------------------------------
  logic [63:0] mul_a_ext;
  logic [63:0] mul_b_ext;
  logic [63:0] mul_prod;
  logic [63:0] mul_pipe_q [MUL_DEPTH];
  logic [63:0] mul_result;

  always_comb begin
    mul_a_ext = {{32{mul_signed_q & a_q[31]}}, a_q};
    mul_b_ext = {{32{mul_signed_q & b_q[31]}}, b_q};
    mul_prod  = mul_a_ext * mul_b_ext;
  end

  // The chain carries no control; the sequencer only reads the tap in the
  // final busy cycle, by which time it holds this operation's product.
  always_ff @(posedge clk) begin
    mul_pipe_q[0] <= mul_prod;
    for (int k = 1; k < MUL_DEPTH; k++) begin
      mul_pipe_q[k] <= mul_pipe_q[k-1];
    end
  end

  assign mul_result = (MUL_CYCLES == 1) ? mul_prod : mul_pipe_q[MUL_TAP];

  // ---------------------------------------------------------------------------
  // Divider: magnitudes go in at acceptance, sign fixup happens on commit.
  // ---------------------------------------------------------------------------
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic        div_valid;
  logic [31:0] div_lo;
  logic [31:0] div_hi;

  div_radix2 u_div (
    .clk       (clk),
    .rst       (reset),
    .start     (div_start),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .kill      (md.flush),
    .quotient  (div_quo),
    .remainder (div_rem),
    .valid     (div_valid)
  );

  // Zero divisor returns all-ones quotient and the untouched dividend.
  // 8000_0000 / FFFF_FFFF needs no special case: magnitude 2^31 / 1 with no
  // negation yields 8000_0000 and remainder 0.
  always_comb begin
    if (dz_q) begin
      div_lo = 32'hFFFF_FFFF;
      div_hi = a_q;
    end else begin
      div_lo = q_neg_q ? (~div_quo + 32'd1) : div_quo;
      div_hi = r_neg_q ? (~div_rem + 32'd1) : div_rem;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      mul_signed_q <= 1'b0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
      dz_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (md.flush) begin
        // Flush beats everything, including a same-cycle request.
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (take_req) begin
              if (op_is_mul) begin
                state_q      <= MUL_RUN;
                busy_q       <= 1'b1;
                cnt_q        <= 3'd1;
                a_q          <= md.srca;
                b_q          <= md.srcb;
                mul_signed_q <= (md.op == MD_MULT);
              end else if (op_is_div) begin
                state_q <= DIV_RUN;
                busy_q  <= 1'b1;
                a_q     <= md.srca;
                b_q     <= md.srcb;
                dz_q    <= (md.srcb == 32'd0);
                q_neg_q <= op_signed_div && (md.srca[31] ^ md.srcb[31]);
                r_neg_q <= op_signed_div && md.srca[31];
              end else if (md.op == MD_MTHI) begin
                hi_q <= md.srca;
              end else if (md.op == MD_MTLO) begin
                lo_q <= md.srca;
              end
            end
          end
          MUL_RUN: begin
            if (cnt_q == 3'(MUL_CYCLES)) begin
              {hi_q, lo_q} <= mul_result;
              state_q      <= IDLE;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
          DIV_RUN: begin
            // valid arrives in busy cycle DIV_ITER+1; this edge is the fixup.
            if (div_valid) begin
              hi_q    <= div_hi;
              lo_q    <= div_lo;
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign md.busy     = busy_q;
  assign md.done     = done_q;
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit: directed cases, boundary divides,
// flush/reset cancellation and a short random mix, checked against an
// expected-result queue filled from an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int MUL_CYCLES = 2;

  logic      clk;
  logic      reset;
  md_state_t dbg_state;

  muldiv_if md_bus ();

  muldiv_unit #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk         (clk),
    .reset       (reset),
    .md          (md_bus.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [63:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (md_bus.done === 1'b1) done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: returns {hi, lo}.
  function automatic logic [63:0] model(input md_op_t o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic [31:0]        q;
    logic [31:0]        r;
    model = '0;
    case (o)
      MD_MULT: begin
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        model = sa * sb;
      end
      MD_MULTU: model = {32'd0, a} * {32'd0, b};
      MD_DIVU: begin
        if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
        else            model = {a % b, a / b};
      end
      MD_DIV: begin
        if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'd0, 32'h8000_0000};
        else begin
          x = a;
          y = b;
          q = x / y;
          r = x % y;
          model = {r, q};
        end
      end
      default: model = '0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (called at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count busy cycles from cycle 1, then check the completion cycle.
  task automatic wait_result(input int exp_cycles, input bit has_result);
    int          n;
    logic [63:0] e;
    n = 0;
    while (md_bus.busy === 1'b1 && n < 200) begin
      step();
      n++;
    end
    check_eq("busy_cycles", n, exp_cycles);
    if (has_result) begin
      check_eq("done_pulse", md_bus.done, 1'b1);
      check_eq("sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("hi", md_bus.hi, e[63:32]);
        check_eq("lo", md_bus.lo, e[31:0]);
      end
      step();
      check_eq("done_width", md_bus.done, 1'b0);
    end else begin
      check_eq("no_done", md_bus.done, 1'b0);
    end
  endtask

  task automatic run_op(input md_op_t o, input logic [31:0] a, input logic [31:0] b);
    bit is_md;
    int cyc;
    is_md = (o == MD_MULT) || (o == MD_MULTU) || (o == MD_DIV) || (o == MD_DIVU);
    cyc   = (o == MD_MULT || o == MD_MULTU) ? MUL_CYCLES :
            (o == MD_DIV  || o == MD_DIVU)  ? DIV_CYCLES : 0;
    if (is_md) exp_q.push_back(model(o, a, b));
    md_bus.req  = 1'b1;
    md_bus.op   = o;
    md_bus.srca = a;
    md_bus.srcb = b;
    step();
    md_bus.req = 1'b0;
    md_bus.op  = MD_NONE;
    wait_result(cyc, is_md);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int      d0;
    md_op_t  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    md_bus.req   = 1'b0;
    md_bus.op    = MD_NONE;
    md_bus.srca  = '0;
    md_bus.srcb  = '0;
    md_bus.flush = 1'b0;
    reset        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check_eq("rst_hi", md_bus.hi, 0);
    check_eq("rst_lo", md_bus.lo, 0);
    check_eq("rst_busy", md_bus.busy, 0);
    check_eq("rst_done", md_bus.done, 0);
    check_eq("rst_state", dbg_state, IDLE);

    // MTHI / MTLO
    run_op(MD_MTHI, 32'h1234_5678, 32'd0);
    run_op(MD_MTLO, 32'h9ABC_DEF0, 32'd0);
    check_eq("mthi", md_bus.hi, 32'h1234_5678);
    check_eq("mtlo", md_bus.lo, 32'h9ABC_DEF0);

    // MD_NONE with req: no effect
    run_op(MD_NONE, 32'hDEAD_BEEF, 32'h1);
    check_eq("none_hi", md_bus.hi, 32'h1234_5678);
    check_eq("none_lo", md_bus.lo, 32'h9ABC_DEF0);

    // Directed multiplies and divides
    run_op(MD_MULT,  32'hFFFF_FFFE, 32'd3);
    run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2);
    run_op(MD_DIVU,  32'd7, 32'd2);
    run_op(MD_DIVU,  32'd5, 32'd0);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd0);

    // Flush with a simultaneous MTHI in idle: request dropped
    md_bus.req   = 1'b1;
    md_bus.op    = MD_MTHI;
    md_bus.srca  = 32'hCAFE_0000;
    md_bus.flush = 1'b1;
    step();
    md_bus.req   = 1'b0;
    md_bus.op    = MD_NONE;
    md_bus.flush = 1'b0;
    check_eq("flush_mthi_drop", md_bus.hi, 32'hFFFF_FFF9);

    // DIV cancelled by flush at busy cycle 10 while the next request is held
    run_op(MD_MTHI, 32'd1, 32'd0);
    run_op(MD_MTLO, 32'd2, 32'd0);
    d0 = done_cnt;
    md_bus.req  = 1'b1;
    md_bus.op   = MD_DIV;
    md_bus.srca = 32'd100;
    md_bus.srcb = 32'd7;
    step();                                   // busy cycle 1
    md_bus.op   = MD_MULTU;
    md_bus.srca = 32'd3;
    md_bus.srcb = 32'd4;
    repeat (9) step();                        // busy cycle 10
    check_eq("busy_before_flush", md_bus.busy, 1'b1);
    md_bus.flush = 1'b1;
    step();
    md_bus.flush = 1'b0;
    check_eq("flush_busy", md_bus.busy, 1'b0);
    check_eq("flush_done", md_bus.done, 1'b0);
    check_eq("flush_hi", md_bus.hi, 32'd1);
    check_eq("flush_lo", md_bus.lo, 32'd2);
    check_eq("flush_state", dbg_state, IDLE);
    check_eq("flush_no_done", done_cnt, d0);
    exp_q.push_back(model(MD_MULTU, 32'd3, 32'd4));
    step();                                   // held request taken
    md_bus.req = 1'b0;
    md_bus.op  = MD_NONE;
    check_eq("held_accept", md_bus.busy, 1'b1);
    wait_result(MUL_CYCLES, 1'b1);

    // Flush in the final busy cycle of a multiply discards the result
    d0 = done_cnt;
    md_bus.req  = 1'b1;
    md_bus.op   = MD_MULT;
    md_bus.srca = 32'd5;
    md_bus.srcb = 32'd5;
    step();
    md_bus.req = 1'b0;
    md_bus.op  = MD_NONE;
    repeat (MUL_CYCLES - 1) step();
    md_bus.flush = 1'b1;
    step();
    md_bus.flush = 1'b0;
    repeat (3) step();
    check_eq("lastcyc_flush_lo", md_bus.lo, 32'd12);
    check_eq("lastcyc_flush_done", done_cnt, d0);

    // Reset at busy cycle 1 of a MULT
    d0 = done_cnt;
    md_bus.req  = 1'b1;
    md_bus.op   = MD_MULT;
    md_bus.srca = 32'h0001_0000;
    md_bus.srcb = 32'h0001_0000;
    step();
    md_bus.req = 1'b0;
    md_bus.op  = MD_NONE;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("mid_rst_hi", md_bus.hi, 0);
    check_eq("mid_rst_lo", md_bus.lo, 0);
    check_eq("mid_rst_busy", md_bus.busy, 0);
    repeat (4) step();
    check_eq("mid_rst_no_done", done_cnt, d0);
    check_eq("mid_rst_hi_late", md_bus.hi, 0);

    // Random mix
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0: rop = MD_MULT;
        1: rop = MD_MULTU;
        2: rop = MD_DIV;
        default: rop = MD_DIVU;
      endcase
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      run_op(rop, ra, rb);
    end

    check_eq("sb_final_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: got no finish expected finish before limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

endmodule
